tdm_demux: RTL and testbench

- Receive-side counterpart of the team's time-division multiplexed serial link.
- Accepts a serial bit stream in which NUM_CH channel words of WIDTH bits are interleaved one channel after another.
- Frame boundaries are marked by a start strobe on the first bit.
- Deserializes the stream and routes each completed word into its own channel register.
- Presents all channel registers as one flat parallel bus, with per-channel and per-frame valid indications.

---
 rtl/tdm_demux_if.sv | 26 ++
 rtl/tdm_demux.sv | 164 ++++++++++++++++
 tb/tb_tdm_demux.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_if.sv
// Serial-in / parallel-out bundle of the TDM link receiver.
// The master side drives the serial stream; the slave side (the demux) drives the
// parallel channel registers and status strobes.
interface tdm_demux_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  logic                    in;
  logic                    in_valid;
  logic                    frame_start;
  logic [NUM_CH*WIDTH-1:0] out;
  logic [NUM_CH-1:0]       ch_valid;
  logic                    out_valid;
  logic                    frame_err;
  logic                    busy;

  modport master (
    output in, in_valid, frame_start,
    input  out, ch_valid, out_valid, frame_err, busy
  );

  modport slave (
    input  in, in_valid, frame_start,
    output out, ch_valid, out_valid, frame_err, busy
  );
endinterface

// File: rtl/tdm_demux.sv
// TDM serial link receiver: deserializes MSB-first words, routes word k of a frame
// into channel register k, and flags frame completion / mid-frame restarts.
module tdm_demux #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WIDTH-1:0]        r_shreg;
  logic [BW-1:0]           r_bit_cnt;
  logic [CW-1:0]           r_ch_cnt;
  logic [NUM_CH*WIDTH-1:0] r_out;
  logic [NUM_CH-1:0]       r_ch_valid;
  logic                    r_out_valid;
  logic                    r_frame_err;

  logic                    w_restart;
  logic                    w_abort;
  logic                    w_shift;
  logic                    w_word_done;
  logic                    w_frame_done;
  logic [WIDTH-1:0]        w_word;

  // The word being completed includes the bit arriving on this edge.
  assign w_word = {r_shreg[WIDTH-2:0], bus.in};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control decode; a frame_start in RECV restarts the frame.
  always_comb begin
    w_state_nxt  = r_state;
    w_restart    = 1'b0;
    w_abort      = 1'b0;
    w_shift      = 1'b0;
    w_word_done  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && bus.frame_start) begin
          w_restart   = 1'b1;
          w_state_nxt = S_RECV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RECV: begin
        if (bus.in_valid) begin
          if (bus.frame_start) begin
            w_restart   = 1'b1;
            w_abort     = 1'b1;
            w_state_nxt = S_RECV;
          end else begin
            w_shift = 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
              w_word_done = 1'b1;
              if (r_ch_cnt == LAST_CH) begin
                w_frame_done = 1'b1;
                w_state_nxt  = S_IDLE;
              end else begin
                w_state_nxt  = S_RECV;
              end
            end else begin
              w_word_done = 1'b0;
            end
          end
        end else begin
          w_state_nxt = S_RECV;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Shift register and bit/channel counters; in_valid low holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_ch_cnt  <= '0;
    end else if (w_restart) begin
      r_shreg   <= {{(WIDTH-1){1'b0}}, bus.in};
      r_bit_cnt <= BW'(1);
      r_ch_cnt  <= '0;
    end else if (w_shift) begin
      r_shreg <= w_word;
      if (w_word_done) begin
        r_bit_cnt <= '0;
        r_ch_cnt  <= w_frame_done ? '0 : r_ch_cnt + CW'(1);
      end else begin
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
    end
  end

  // Channel registers: only reset clears them; each word lands in its channel slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_word_done && (r_ch_cnt == CW'(k))) begin
          r_out[k*WIDTH +: WIDTH] <= w_word;
        end
      end
    end
  end

  // Per-channel valid flags, cleared whenever a new frame begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_valid <= '0;
    end else if (w_restart) begin
      r_ch_valid <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_word_done && (r_ch_cnt == CW'(k))) begin
          r_ch_valid[k] <= 1'b1;
        end
      end
    end
  end

  // One-cycle completion and abort strobes; they are mutually exclusive by decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_out_valid <= w_frame_done;
      r_frame_err <= w_abort;
    end
  end

  assign bus.out       = r_out;
  assign bus.ch_valid  = r_ch_valid;
  assign bus.out_valid = r_out_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state == S_RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (NUM_CH=4, WIDTH=8). Frame words are written as
// 32-bit values with channel 0 in the low byte; bits go out channel 0 first, MSB first.
module tb_tdm_demux;

  logic clk;
  logic rst_n;
  int   errs   = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   ov_cnt = 0;
  int   fe_cnt = 0;
  int   both_cnt = 0;
  int   ov_last = 0;
  int   ov_prev = 0;

  tdm_demux_if #(.NUM_CH(4), .WIDTH(8)) bus ();

  tdm_demux #(.NUM_CH(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      ov_cnt  = ov_cnt + 1;
      ov_prev = ov_last;
      ov_last = cyc;
    end
    if (bus.frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (bus.out_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      bus.in          = f[(i/8)*8 + 7 - (i%8)];
      bus.in_valid    = 1'b1;
      bus.frame_start = (i == 0);
      @(posedge clk);
      #1;
      bus.in_valid    = 1'b0;
      bus.frame_start = 1'b0;
    end
  endtask

  // Idle cycle with junk on the data lines that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in          = 1'($urandom_range(0, 1));
      bus.frame_start = 1'b1;
      bus.in_valid    = 1'b0;
      @(posedge clk);
      #1;
      bus.frame_start = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out"},  bus.out, 32'h0000_0000);
    check({tag, "_chv"},  32'(bus.ch_valid), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_ov"},   32'(bus.out_valid), 32'h0);
    check({tag, "_fe"},   32'(bus.frame_err), 32'h0);
  endtask

  initial begin
    int t0;
    int ov_base;
    int fe_base;

    bus.in = 1'b0; bus.in_valid = 1'b0; bus.frame_start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: contiguous frame A5,3C,FF,01
    ov_base = ov_cnt;
    send_bits(32'h01FF3CA5, 0, 0);
    t0 = cyc;
    check("t1_busy_start", 32'(bus.busy), 32'h1);
    send_bits(32'h01FF3CA5, 1, 31);
    check("t1_out",   bus.out, 32'h01FF3CA5);
    check("t1_ov",    32'(bus.out_valid), 32'h1);
    check("t1_chv",   32'(bus.ch_valid), 32'hF);
    check("t1_busy",  32'(bus.busy), 32'h0);
    idle(2);
    check("t1_ov_low", 32'(bus.out_valid), 32'h0);
    check("t1_ov_cnt", 32'(ov_cnt - ov_base), 32'd1);
    check("t1_lat",    32'(ov_last - t0), 32'd31);

    // 2: same frame with 3-cycle stalls after bits 5, 12, 30
    ov_base = ov_cnt;
    fe_base = fe_cnt;
    for (int i = 0; i < 32; i++) begin
      send_bits(32'h01FF3CA5, i, i);
      if (i == 0) t0 = cyc;
      if (i == 5 || i == 12 || i == 30) idle(3);
    end
    check("t2_out", bus.out, 32'h01FF3CA5);
    check("t2_ov",  32'(bus.out_valid), 32'h1);
    idle(2);
    check("t2_ov_cnt", 32'(ov_cnt - ov_base), 32'd1);
    check("t2_lat",    32'(ov_last - t0), 32'd40);
    check("t2_fe_cnt", 32'(fe_cnt - fe_base), 32'd0);

    // 3: frame 11,22,33,44 aborted at bit 19, then 55,66,77,88
    ov_base = ov_cnt;
    fe_base = fe_cnt;
    send_bits(32'h44332211, 0, 18);
    check("t3_chv_pre", 32'(bus.ch_valid), 32'h3);
    check("t3_out_pre", bus.out, 32'h01FF2211);
    send_bits(32'h88776655, 0, 0);
    check("t3_fe",      32'(bus.frame_err), 32'h1);
    check("t3_chv_ab",  32'(bus.ch_valid), 32'h0);
    check("t3_out_ab",  32'(bus.out[15:0]), 32'h2211);
    check("t3_busy_ab", 32'(bus.busy), 32'h1);
    send_bits(32'h88776655, 1, 1);
    check("t3_fe_low",  32'(bus.frame_err), 32'h0);
    send_bits(32'h88776655, 2, 31);
    check("t3_out", bus.out, 32'h88776655);
    check("t3_ov",  32'(bus.out_valid), 32'h1);
    idle(2);
    check("t3_ov_cnt", 32'(ov_cnt - ov_base), 32'd1);
    check("t3_fe_cnt", 32'(fe_cnt - fe_base), 32'd1);

    // 4: back-to-back frames, no gap
    ov_base = ov_cnt;
    send_bits(32'h04030201, 0, 31);
    check("t4_out1", bus.out, 32'h04030201);
    check("t4_ov1",  32'(bus.out_valid), 32'h1);
    send_bits(32'h40302010, 0, 0);
    check("t4_chv_clr", 32'(bus.ch_valid), 32'h0);
    check("t4_busy",    32'(bus.busy), 32'h1);
    send_bits(32'h40302010, 1, 31);
    check("t4_out2", bus.out, 32'h40302010);
    check("t4_ov2",  32'(bus.out_valid), 32'h1);
    idle(2);
    check("t4_ov_cnt", 32'(ov_cnt - ov_base), 32'd2);
    check("t4_gap",    32'(ov_last - ov_prev), 32'd32);

    // 5: idle noise after reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ov_base = ov_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.in          = 1'($urandom_range(0, 1));
      bus.in_valid    = 1'b1;
      bus.frame_start = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check_zero("t5");
    check("t5_ov_cnt", 32'(ov_cnt - ov_base), 32'd0);

    // 6: async reset mid-frame at bit 17
    send_bits(32'hDDCCBBAA, 0, 16);
    check("t6_out_pre", bus.out, 32'h0000BBAA);
    check("t6_chv_pre", 32'(bus.ch_valid), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    send_bits(32'hDDCCBBAA, 17, 31);
    check_zero("t6_ign");
    ov_base = ov_cnt;
    send_bits(32'hCAFEBABE, 0, 31);
    check("t6_out", bus.out, 32'hCAFEBABE);
    check("t6_ov",  32'(bus.out_valid), 32'h1);
    check("t6_chv", 32'(bus.ch_valid), 32'hF);
    idle(2);
    check("t6_ov_cnt", 32'(ov_cnt - ov_base), 32'd1);
    check("both_high", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
